keypoint_sram_arbiter: RTL and testbench
========================================

Name: keypoint_sram_arbiter

Overview:
- Shares one single-port keypoint SRAM write port between the two DoG-layer keypoint writers (layer-1 and layer-2 filter outputs, one {row,col} per write strobe).
- Each requester gets a small FIFO; a round-robin arbiter drains the FIFOs into the SRAM at one write per cycle.
- Also tracks per-layer counts, saturation at SRAM capacity, overflow, and frame start/drain/done sequencing.
- Sits between the detect/filter stage and the downstream descriptor stage, which reads the merged keypoint list.

Parameters:
- DATA_W, 19, keypoint payload width: row 9 bit, col 10 bit, row in MSBs.
- ADDR_W, 11, SRAM address width (2K keypoints).
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, minimum 2.
- MAX_KP, 2048, SRAM capacity in entries; must not exceed 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; honoured only in IDLE.
- frame_done  in  1  pulse: the detector has issued its last request for the frame.
- req0_we  in  1  layer-1 write strobe.
- req0_din  in  DATA_W  layer-1 keypoint {row,col}.
- req1_we  in  1  layer-2 write strobe.
- req1_din  in  DATA_W  layer-2 keypoint.
- kp_we  out  1  SRAM write enable (registered).
- kp_addr  out  ADDR_W  SRAM write address (registered).
- kp_din  out  DATA_W (DATA_W+1 with tag)  SRAM write data (registered).
- kp_count_0  out  ADDR_W+1  layer-1 entries written this frame.
- kp_count_1  out  ADDR_W+1  layer-2 entries written this frame.
- overflow  out  2  sticky per-requester FIFO-full drop flag; bit0 = req0, bit1 = req1.
- saturated  out  1  sticky: SRAM full, at least one entry discarded.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the frame is fully written.

Behaviour:
- Reset (asynchronous) clears state to IDLE, empties both FIFOs, and sets all outputs to 0. Round-robin pointer last_grant = 1, so req0 wins the first tie.
- An assertion of rst_n during RUN or DRAIN aborts the frame; no write is emitted after reset asserts.

FSM states:
- IDLE: waits for start. On start, clears kp_addr, both counts, overflow, saturated and the FIFOs, then goes to RUN.
- RUN: accepts pushes and arbitrates. On frame_done, goes to DRAIN.
- DRAIN: still accepts pushes. When both FIFOs are empty and no pop is in flight this cycle, goes to DONE.
- DONE: done = 1 for exactly one cycle, then goes to IDLE. kp_addr and the counts hold their values until the next start.
- start outside IDLE is ignored. frame_done outside RUN is ignored.
- If start and frame_done are high together in IDLE, start is taken and frame_done is ignored.

Push rules:
- A reqN_we pulse pushes reqN_din into FIFO N in RUN/DRAIN only; strobes in IDLE/DONE are ignored.
- A push into a full FIFO is accepted if FIFO N pops in the same cycle.
- Otherwise the push is dropped and overflow[N] is set sticky.
- Simultaneous req0_we and req1_we are both legal.

Arbitration and timing:
- Each cycle in RUN/DRAIN, the arbiter grants one non-empty FIFO.
- If both are non-empty, it grants the FIFO other than last_grant and then updates last_grant.
- If only one is non-empty, it grants that one.
- Pop and write register on the same edge: kp_we = 1, kp_din = head, kp_addr = current write pointer. The write pointer and kp_count_N increment after that edge.
- Latency: a strobe sampled at edge k puts kp_we high in the cycle following edge k+1, i.e. 2 cycles when uncontended.
- kp_we is low in any cycle with no grant.

Saturation:
- When the write pointer equals MAX_KP, granted entries are still popped but not written: kp_we = 0, the counts do not increment, saturated = 1.
- kp_addr holds at MAX_KP-1 and never wraps.

Count rules:
- kp_count_0 + kp_count_1 equals the number of kp_we pulses in the frame.

Optional Feature:
- Macro KP_LAYER_TAG_EN.
- Defined: kp_din is DATA_W+1 bits, with MSB = granted source (0 = layer-1, 1 = layer-2), so the descriptor stage can separate layers from the merged list.
- Undefined: kp_din is DATA_W bits, carrying the raw payload only; layer origin is recoverable only from counts and order.

Test Plan:
- Reset mid-RUN with 3 entries queued: pulse rst_n low → kp_we, counts and busy go 0 immediately; after release the state is IDLE; no further writes.
- Single push: start, then req0_we with din = {9'd5,10'd37} → exactly 2 cycles later kp_we = 1, kp_addr = 0, kp_din = 0x01425; kp_count_0 = 1.
- Contention: req0 and req1 strobed together on 3 consecutive cycles → writes alternate 0,1,0,1,0,1 at addresses 0–5; counts 3/3; no overflow.
- Overflow: with FIFO_DEPTH = 4, req0 pushes on every cycle while req1 also pushes on every cycle for 10 cycles → overflow[0] and overflow[1] are set; kp_count_0 + kp_count_1 equals the total kp_we pulses.
- Saturation: with MAX_KP = 8, push 10 req0 entries → 8 writes at addresses 0–7, saturated = 1, kp_count_0 = 8, kp_addr stays at 7.
- Drain/done: frame_done with 2 entries queued → 2 writes, then done is high for 1 cycle, then IDLE with busy = 0; an empty frame (start then frame_done) produces done 2 cycles after frame_done with no writes.

Source files
------------

// File: rtl/keypoint_sram_arbiter_if.sv
// Keypoint SRAM arbiter bus: frame control, two keypoint write requesters,
// the merged SRAM write port and the frame status outputs.
// When KP_LAYER_TAG_EN is defined, kp_din carries one extra MSB holding the source layer.
interface keypoint_sram_arbiter_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 11
);
`ifdef KP_LAYER_TAG_EN
    localparam int KP_W = DATA_W + 1;
`else
    localparam int KP_W = DATA_W;
`endif

    logic              start;
    logic              frame_done;
    logic              req0_we;
    logic [DATA_W-1:0] req0_din;
    logic              req1_we;
    logic [DATA_W-1:0] req1_din;
    logic              kp_we;
    logic [ADDR_W-1:0] kp_addr;
    logic [KP_W-1:0]   kp_din;
    logic [ADDR_W:0]   kp_count_0;
    logic [ADDR_W:0]   kp_count_1;
    logic [1:0]        overflow;
    logic              saturated;
    logic              busy;
    logic              done;

    modport master (
        output start, frame_done, req0_we, req0_din, req1_we, req1_din,
        input  kp_we, kp_addr, kp_din, kp_count_0, kp_count_1,
               overflow, saturated, busy, done
    );

    modport slave (
        input  start, frame_done, req0_we, req0_din, req1_we, req1_din,
        output kp_we, kp_addr, kp_din, kp_count_0, kp_count_1,
               overflow, saturated, busy, done
    );
endinterface

// File: rtl/keypoint_sram_arbiter.sv
// Merges the layer-1 and layer-2 keypoint streams into one single-port SRAM.
// Each requester has a small FIFO; a round-robin arbiter pops one entry per
// cycle into the registered SRAM write port, with per-layer counts, overflow
// and saturation tracking, and IDLE/RUN/DRAIN/DONE frame sequencing.
// Optional macro KP_LAYER_TAG_EN: prepend the granted source bit to kp_din.
module keypoint_sram_arbiter #(
    parameter int DATA_W     = 19,
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_KP     = 2048
) (
    input logic                   clk,
    input logic                   rst_n,
    keypoint_sram_arbiter_if.slave bus
);
`ifdef KP_LAYER_TAG_EN
    localparam int KP_W = DATA_W + 1;
`else
    localparam int KP_W = DATA_W;
`endif
    localparam int              PW     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] KP_LIM = (ADDR_W + 1)'(MAX_KP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic              busy_r;
    logic              done_r;
    logic              active;
    logic              start_go;

    logic [1:0]        we_in;
    logic [DATA_W-1:0] din_in [2];
    logic [DATA_W-1:0] fifo_mem [2][FIFO_DEPTH];
    logic [PW:0]       fifo_wp [2];
    logic [PW:0]       fifo_rp [2];
    logic [1:0]        fifo_empty;
    logic [1:0]        fifo_full;
    logic [1:0]        push_ok;
    logic [1:0]        push_drop;

    logic [1:0]        pop_p0;
    logic              any_pop_p0;
    logic              src_p0;
    logic [DATA_W-1:0] head_p0;
    logic [KP_W-1:0]   head_kp_p0;
    logic              can_write_p0;
    logic              last_grant;

    logic [ADDR_W:0]   wptr;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [KP_W-1:0]   wr_data_p1;
    logic [ADDR_W:0]   cnt0;
    logic [ADDR_W:0]   cnt1;
    logic [1:0]        ovf;
    logic              sat;

    // Write pointer advance that parks at the SRAM capacity instead of wrapping.
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (v == KP_LIM) ? v : v + 1'b1;
    endfunction

    assign active    = (state == RUN) || (state == DRAIN);
    assign start_go  = (state == IDLE) && bus.start;
    assign we_in     = {bus.req1_we, bus.req0_we};
    assign din_in[0] = bus.req0_din;
    assign din_in[1] = bus.req1_din;

    // FIFO flags, round-robin grant and push acceptance (a full FIFO accepts when it pops).
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        push_ok    = '0;
        push_drop  = '0;
        for (int n = 0; n < 2; n++) begin
            fifo_empty[n] = (fifo_wp[n] == fifo_rp[n]);
            fifo_full[n]  = (fifo_wp[n][PW] != fifo_rp[n][PW]) &&
                            (fifo_wp[n][PW-1:0] == fifo_rp[n][PW-1:0]);
        end
        pop_p0[0] = active && !fifo_empty[0] && (fifo_empty[1] || last_grant);
        pop_p0[1] = active && !fifo_empty[1] && (fifo_empty[0] || !last_grant);
        for (int n = 0; n < 2; n++) begin
            push_ok[n]   = active && we_in[n] && (!fifo_full[n] || pop_p0[n]);
            push_drop[n] = active && we_in[n] && fifo_full[n] && !pop_p0[n];
        end
        any_pop_p0   = |pop_p0;
        src_p0       = pop_p0[1];
        head_p0      = fifo_mem[src_p0][fifo_rp[src_p0][PW-1:0]];
        head_kp_p0   = KP_W'({src_p0, head_p0});
        can_write_p0 = (wptr != KP_LIM);
    end

    // FIFO pointers: cleared on reset and on frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                fifo_wp[n] <= '0;
                fifo_rp[n] <= '0;
            end
        end else if (start_go) begin
            for (int n = 0; n < 2; n++) begin
                fifo_wp[n] <= '0;
                fifo_rp[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_ok[n]) fifo_wp[n] <= fifo_wp[n] + 1'b1;
                if (pop_p0[n])  fifo_rp[n] <= fifo_rp[n] + 1'b1;
            end
        end
    end

    // FIFO storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push_ok[n]) fifo_mem[n][fifo_wp[n][PW-1:0]] <= din_in[n];
        end
    end

    // p0 -> p1: registered SRAM write, counts, sticky overflow/saturation flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            wptr       <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            ovf        <= '0;
            sat        <= 1'b0;
        end else if (start_go) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wptr       <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            ovf        <= '0;
            sat        <= 1'b0;
        end else begin
            wr_vld_p1 <= any_pop_p0 && can_write_p0;
            ovf       <= ovf | push_drop;
            if (any_pop_p0) last_grant <= src_p0;
            if (any_pop_p0 && can_write_p0) begin
                wr_addr_p1 <= wptr[ADDR_W-1:0];
                wr_data_p1 <= head_kp_p0;
                wptr       <= sat_inc(wptr);
                if (src_p0) cnt1 <= cnt1 + 1'b1;
                else        cnt0 <= cnt0 + 1'b1;
            end
            if (any_pop_p0 && !can_write_p0) sat <= 1'b1;
        end
    end

    // Frame sequencer with registered busy/done; DRAIN waits until nothing is left in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.frame_done) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty == 2'b11 && !any_pop_p0 && push_ok == 2'b00) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.kp_we      = wr_vld_p1;
    assign bus.kp_addr    = wr_addr_p1;
    assign bus.kp_din     = wr_data_p1;
    assign bus.kp_count_0 = cnt0;
    assign bus.kp_count_1 = cnt1;
    assign bus.overflow   = ovf;
    assign bus.saturated  = sat;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_keypoint_sram_arbiter.sv
// Bench for keypoint_sram_arbiter: cycle-exact vector table for single push and
// contention, plus a write scoreboard for saturation and drain/done sequences.
module tb_keypoint_sram_arbiter;
    localparam int DATA_W     = 19;
    localparam int ADDR_W     = 11;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_KP     = 8;
`ifdef KP_LAYER_TAG_EN
    localparam int KP_W = DATA_W + 1;
`else
    localparam int KP_W = DATA_W;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypoint_sram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    keypoint_sram_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_KP(MAX_KP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [KP_W-1:0]   din;
    } wr_t;

    typedef struct {
        bit                restart;
        bit                we0;
        logic [DATA_W-1:0] d0;
        bit                we1;
        logic [DATA_W-1:0] d1;
        bit                exp_we;
        int                exp_addr;
        int                exp_src;
        logic [DATA_W-1:0] exp_d;
        int                c0;
        int                c1;
    } vec_t;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   we_cnt = 0;
    bit   sb_on  = 0;
    wr_t  sb_q[$];
    wr_t  mon_e;
    vec_t tbl[$];

    function automatic logic [KP_W-1:0] kpd(int src, logic [DATA_W-1:0] d);
        return KP_W'({src[0], d});
    endfunction

    function automatic vec_t mk(bit rs, bit w0, logic [DATA_W-1:0] d0, bit w1,
                                logic [DATA_W-1:0] d1, bit ew, int ea, int es,
                                logic [DATA_W-1:0] ed, int c0, int c1);
        vec_t v;
        v.restart = rs; v.we0 = w0; v.d0 = d0; v.we1 = w1; v.d1 = d1;
        v.exp_we = ew; v.exp_addr = ea; v.exp_src = es; v.exp_d = ed;
        v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: counts every SRAM write and, when armed, compares it with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.kp_we === 1'b1) begin
            we_cnt++;
            if (sb_on) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_extra: unexpected write addr 0x%0h din 0x%0h",
                             bus.kp_addr, bus.kp_din);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_addr", 32'(bus.kp_addr), 32'(mon_e.addr));
                    check("sb_din", 32'(bus.kp_din), 32'(mon_e.din));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.start = 0; bus.frame_done = 0;
        bus.req0_we = 0; bus.req0_din = '0;
        bus.req1_we = 0; bus.req1_din = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        sb_q.delete();
        #12;
        rst_n = 1;
        tick();
    endtask

    task automatic do_start();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic sb_push(int addr, int src, logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.din  = kpd(src, d);
        sb_q.push_back(e);
    endtask

    initial begin : main
        logic [DATA_W-1:0] d;
        bit seen;
        idle_inputs();

        // Reset state
        #3;
        check("rst_kp_we", 32'(bus.kp_we), 0);
        check("rst_kp_addr", 32'(bus.kp_addr), 0);
        check("rst_kp_din", 32'(bus.kp_din), 0);
        check("rst_count_0", 32'(bus.kp_count_0), 0);
        check("rst_count_1", 32'(bus.kp_count_1), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_saturated", 32'(bus.saturated), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        #9;
        rst_n = 1;
        tick();

        // Vector table: single push, then a fresh frame with three contended cycles
        tbl.push_back(mk(1, 1, {9'd5, 10'd37}, 0, '0, 0, 0, 0, '0, 0, 0));
        tbl.push_back(mk(0, 0, '0, 0, '0, 1, 0, 0, {9'd5, 10'd37}, 1, 0));
        tbl.push_back(mk(0, 0, '0, 0, '0, 0, 0, 0, '0, 1, 0));
        tbl.push_back(mk(1, 1, 19'h00101, 1, 19'h40201, 0, 0, 0, '0, 0, 0));
        tbl.push_back(mk(0, 1, 19'h00102, 1, 19'h40202, 1, 0, 0, 19'h00101, 1, 0));
        tbl.push_back(mk(0, 1, 19'h00103, 1, 19'h40203, 1, 1, 1, 19'h40201, 1, 1));
        tbl.push_back(mk(0, 0, '0, 0, '0, 1, 2, 0, 19'h00102, 2, 1));
        tbl.push_back(mk(0, 0, '0, 0, '0, 1, 3, 1, 19'h40202, 2, 2));
        tbl.push_back(mk(0, 0, '0, 0, '0, 1, 4, 0, 19'h00103, 3, 2));
        tbl.push_back(mk(0, 0, '0, 0, '0, 1, 5, 1, 19'h40203, 3, 3));
        tbl.push_back(mk(0, 0, '0, 0, '0, 0, 0, 0, '0, 3, 3));
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].restart) begin
                do_reset();
                do_start();
            end
            bus.req0_we = tbl[i].we0; bus.req0_din = tbl[i].d0;
            bus.req1_we = tbl[i].we1; bus.req1_din = tbl[i].d1;
            tick();
            idle_inputs();
            check($sformatf("vec%0d_kp_we", i), 32'(bus.kp_we), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we) begin
                check($sformatf("vec%0d_kp_addr", i), 32'(bus.kp_addr), 32'(tbl[i].exp_addr));
                check($sformatf("vec%0d_kp_din", i), 32'(bus.kp_din),
                      32'(kpd(tbl[i].exp_src, tbl[i].exp_d)));
            end
            check($sformatf("vec%0d_count_0", i), 32'(bus.kp_count_0), 32'(tbl[i].c0));
            check($sformatf("vec%0d_count_1", i), 32'(bus.kp_count_1), 32'(tbl[i].c1));
        end
        check("contention_overflow", 32'(bus.overflow), 0);
        check("contention_saturated", 32'(bus.saturated), 0);

        // Reset mid-RUN with 3 entries queued
        do_reset();
        do_start();
        for (int i = 0; i < 2; i++) begin
            bus.req0_we = 1; bus.req0_din = DATA_W'(19'h00200 + i);
            bus.req1_we = 1; bus.req1_din = DATA_W'(19'h40200 + i);
            tick();
        end
        idle_inputs();
        check("abort_pre_kp_we", 32'(bus.kp_we), 1);
        rst_n = 0;
        #1;
        we_cnt = 0;
        check("abort_kp_we", 32'(bus.kp_we), 0);
        check("abort_count_0", 32'(bus.kp_count_0), 0);
        check("abort_count_1", 32'(bus.kp_count_1), 0);
        check("abort_busy", 32'(bus.busy), 0);
        #5;
        rst_n = 1;
        repeat (5) tick();
        check("abort_no_writes", 32'(we_cnt), 0);
        check("abort_idle_busy", 32'(bus.busy), 0);
        bus.req0_we = 1; bus.req0_din = 19'h00333;
        tick();
        idle_inputs();
        repeat (3) tick();
        check("idle_strobe_ignored", 32'(we_cnt), 0);

        // Overflow: both requesters push every cycle for 10 cycles
        do_reset();
        do_start();
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req0_we = 1; bus.req0_din = DATA_W'(19'h00400 + i);
            bus.req1_we = 1; bus.req1_din = DATA_W'(19'h40400 + i);
            tick();
        end
        idle_inputs();
        repeat (20) tick();
        check("ovf_flags", 32'(bus.overflow), 3);
        check("ovf_count_sum", 32'(bus.kp_count_0) + 32'(bus.kp_count_1), 32'(we_cnt));
        check("ovf_writes", 32'(we_cnt), MAX_KP);

        // Saturation: 10 req0 entries into an 8-entry SRAM
        do_reset();
        do_start();
        sb_on = 1;
        for (int i = 0; i < 10; i++) begin
            d = DATA_W'(19'h00500 + i);
            bus.req0_we = 1; bus.req0_din = d;
            if (i < MAX_KP) sb_push(i, 0, d);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        sb_on = 0;
        check("sat_sb_left", 32'(sb_q.size()), 0);
        check("sat_flag", 32'(bus.saturated), 1);
        check("sat_count_0", 32'(bus.kp_count_0), MAX_KP);
        check("sat_count_1", 32'(bus.kp_count_1), 0);
        check("sat_kp_addr", 32'(bus.kp_addr), MAX_KP - 1);
        check("sat_kp_we", 32'(bus.kp_we), 0);

        // Drain/done with 2 entries queued at frame_done
        do_reset();
        do_start();
        sb_on = 1;
        sb_push(0, 0, 19'h00601);
        sb_push(1, 1, 19'h40601);
        bus.req0_we = 1; bus.req0_din = 19'h00601;
        bus.req1_we = 1; bus.req1_din = 19'h40601;
        bus.frame_done = 1;
        tick();
        idle_inputs();
        check("drain_busy", 32'(bus.busy), 1);
        check("drain_done0", 32'(bus.done), 0);
        tick();
        check("drain_we1", 32'(bus.kp_we), 1);
        check("drain_done1", 32'(bus.done), 0);
        tick();
        check("drain_we2", 32'(bus.kp_we), 1);
        check("drain_done2", 32'(bus.done), 0);
        tick();
        check("drain_done_pulse", 32'(bus.done), 1);
        check("drain_we3", 32'(bus.kp_we), 0);
        tick();
        check("drain_done_end", 32'(bus.done), 0);
        check("drain_idle_busy", 32'(bus.busy), 0);
        sb_on = 0;
        check("drain_sb_left", 32'(sb_q.size()), 0);

        // Empty frame: start then frame_done
        do_start();
        we_cnt = 0;
        bus.frame_done = 1;
        tick();
        idle_inputs();
        check("empty_done_early", 32'(bus.done), 0);
        check("empty_busy", 32'(bus.busy), 1);
        tick();
        check("empty_done_pulse", 32'(bus.done), 1);
        tick();
        check("empty_done_end", 32'(bus.done), 0);
        check("empty_idle_busy", 32'(bus.busy), 0);
        check("empty_no_writes", 32'(we_cnt), 0);

        // start and frame_done together in IDLE: frame_done must be ignored
        bus.start = 1; bus.frame_done = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check("startfd_busy", 32'(bus.busy), 1);
        check("startfd_no_done", 32'(bus.done), 0);
        bus.frame_done = 1;
        tick();
        idle_inputs();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.done === 1'b1) seen = 1;
            else tick();
        end
        check("startfd_done_seen", 32'(seen), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
